// File: rtl/fetch_ctrl.sv
// fetch_ctrl: IF-stage sequencer owning the fetch PC, the imem request handshake and redirect capture.
// Build option FETCH_DELAY_SLOT_EN: keep the branch+4 delivery (delay slot) instead of squashing it.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [2:0]  id_cf_type,
  input  logic        id_br_taken,
  input  logic        hazard_stall,
  input  logic [31:0] next_pc,
  output logic [2:0]  pc_sel,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);

  localparam logic [2:0] PC_SEL_ADD4   = 3'd0;
  localparam logic [2:0] PC_SEL_BRANCH = 3'd1;

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t      state;
  logic        pend;
  logic [31:0] tgt;
  logic [31:0] hold_buf;

  logic        redir;
  logic        deliver;
  logic        squash;
  logic [31:0] word;
  logic [31:0] pc_nxt;

  always_comb begin
    redir   = id_valid && !hazard_stall && (id_cf_type != PC_SEL_ADD4) &&
              ((id_cf_type != PC_SEL_BRANCH) || id_br_taken);
    pc_sel  = redir ? id_cf_type : PC_SEL_ADD4;
    deliver = !hazard_stall && (((state == REQ) && imem_ack) || (state == HOLD));
    word    = (state == HOLD) ? hold_buf : imem_rdata;
    // A captured target outranks a fresh redirect: the first redirect wins.
    pc_nxt  = pend ? tgt : (redir ? next_pc : pc + 32'd4);
  end

`ifdef FETCH_DELAY_SLOT_EN
  assign squash = 1'b0;
`else
  assign squash = pend || redir;
`endif

  assign imem_req  = (state == REQ);
  assign imem_addr = pc;
  assign if_valid  = deliver && !squash;
  assign if_instr  = if_valid ? word : 32'h0;
  assign if_pc     = if_valid ? pc : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      pend     <= 1'b0;
      tgt      <= 32'h0;
      hold_buf <= 32'h0;
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (imem_ack && hazard_stall) begin
            hold_buf <= imem_rdata;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (!hazard_stall) state <= REQ;
        end
        default: state <= IDLE;
      endcase

      if (deliver) begin
        pc   <= pc_nxt;
        pend <= 1'b0;
      end else if (redir && !pend) begin
        tgt  <= next_pc;
        pend <= 1'b1;
      end
    end
  end

endmodule
